// File: rtl/fifo_stream_reader.sv
// Read-side controller for the dual-port BRAM FIFO: credit-based read enable,
// latency-absorbing skid buffer, and a valid/ready output stream.
module fifo_stream_reader #(
    parameter int DW         = 24,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = RD_LATENCY + 2,
    parameter int BW         = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rempty,
    output logic          o_rd,
    input  logic [DW-1:0] i_rdata,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_ready,
    output logic [BW-1:0] o_level
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [BW:0] DEPTH_C = (BW + 1)'(BUF_DEPTH);

    logic [RD_LATENCY-1:0] flight_reg, flight_next;
    logic [DW-1:0]         mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
    logic [BW-1:0]         occ_reg, occ_next;
    logic [BW-1:0]         inflight, inflight_next;
    logic [DW-1:0]         data_reg, data_next;
    logic [BW-1:0]         level_reg;
    logic                  push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [BW-1:0] ones(input logic [RD_LATENCY-1:0] v);
        logic [BW-1:0] n = '0;
        for (int i = 0; i < RD_LATENCY; i++) n = n + BW'(v[i]);
        return n;
    endfunction

    assign inflight = ones(flight_reg);
    assign o_rd     = rst && !i_rempty && (({1'b0, occ_reg} + {1'b0, inflight}) < DEPTH_C);
    assign push     = flight_reg[RD_LATENCY-1];
    assign o_valid  = (occ_reg != '0);
    assign pop      = o_valid && i_ready;
    assign o_data   = data_reg;
    assign o_level  = level_reg;

    // Each bit marks one outstanding read; the top bit is the word arriving now.
    assign flight_next[0] = o_rd;
    generate
        for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_flight
            assign flight_next[gi] = flight_reg[gi-1];
        end
    endgenerate

    assign inflight_next = ones(flight_next);

    // The head word lives in data_reg; on a pop it is refilled from the next
    // stored slot, or straight from i_rdata when that arriving word is next.
    always_comb begin
        rd_ptr_inc = ptr_inc(rd_ptr_reg);
        occ_next   = occ_reg + BW'(push) - BW'(pop);
        data_next  = data_reg;
        if (pop) begin
            if (occ_reg > BW'(1))
                data_next = mem[rd_ptr_inc];
            else if (push)
                data_next = i_rdata;
        end else if ((occ_reg == '0) && push) begin
            data_next = i_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= i_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            flight_reg <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            data_reg   <= '0;
            level_reg  <= '0;
        end else begin
            flight_reg <= flight_next;
            occ_reg    <= occ_next;
            data_reg   <= data_next;
            level_reg  <= occ_next + inflight_next;
            if (push)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)
                rd_ptr_reg <= rd_ptr_inc;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model plus end-to-end scoreboard, run on a
// RD_LATENCY=1 instance (directed) and a RD_LATENCY=3 instance (random).
module tb_fifo_stream_reader;
    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, rst_b, i_rempty, i_ready;
    logic [DW-1:0] i_rdata;
    logic          o_rd_a, o_valid_a, o_rd_b, o_valid_b;
    logic [DW-1:0] o_data_a, o_data_b;
    logic [1:0]    o_level_a;
    logic [2:0]    o_level_b;

    fifo_stream_reader #(.DW(DW), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst_a), .i_rempty(i_rempty), .o_rd(o_rd_a), .i_rdata(i_rdata),
        .o_valid(o_valid_a), .o_data(o_data_a), .i_ready(i_ready), .o_level(o_level_a)
    );

    fifo_stream_reader #(.DW(DW), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst_b), .i_rempty(i_rempty), .o_rd(o_rd_b), .i_rdata(i_rdata),
        .o_valid(o_valid_b), .o_data(o_data_b), .i_ready(i_ready), .o_level(o_level_b)
    );

    // Active instance selection; the idle one is held in reset.
    bit            sel;
    int            lat, depth;
    logic          rd_m, valid_m;
    logic [DW-1:0] data_m;
    int            level_m;
    always_comb begin
        rd_m    = sel ? o_rd_b : o_rd_a;
        valid_m = sel ? o_valid_b : o_valid_a;
        data_m  = sel ? o_data_b : o_data_a;
        level_m = sel ? int'(o_level_b) : int'(o_level_a);
    end

    // Words issued by o_rd and not yet accepted downstream, with the cycle at
    // which each becomes visible on the stream.
    typedef struct {
        logic [DW-1:0] w;
        int            avail;
    } ent_t;

    logic [DW-1:0] src[$];
    ent_t          exp_q[$];
    int            cyc, errors, checks, delivered, n, total;
    bit            post_rst, prev_hold;
    logic [DW-1:0] prev_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit emp, input bit chk);
        bit            rd_s, hs_s, exp_valid;
        logic [DW-1:0] w;
        rst_a    = sel ? 1'b0 : r;
        rst_b    = sel ? r : 1'b0;
        i_ready  = rdy;
        i_rempty = emp || (src.size() == 0);
        i_rdata  = DW'($urandom);
        foreach (exp_q[k])
            if (exp_q[k].avail == cyc + 1) i_rdata = exp_q[k].w;
        #2;
        if (chk) begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            check_eq("o_rd", rd_m, r && !i_rempty && (exp_q.size() < depth));
            check_eq("o_level", level_m, exp_q.size());
            check_eq("o_level_bound", level_m <= depth, 1);
            check_eq("o_valid", valid_m, exp_valid);
            if (exp_valid) check_eq("o_data", data_m, exp_q[0].w);
            if (post_rst) check_eq("o_data_rst", data_m, 0);
            if (prev_hold) check_eq("o_data_hold", data_m, prev_data);
        end
        rd_s      = rd_m;
        hs_s      = valid_m && rdy;
        prev_hold = r && valid_m && !rdy;
        prev_data = data_m;
        @(posedge clk);
        #1;
        w = '0;
        if (rd_s && src.size() > 0) w = src.pop_front();
        if (!r) begin
            exp_q.delete();
            post_rst = 1'b1;
        end else begin
            post_rst = 1'b0;
            if (hs_s && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                delivered++;
            end
            if (rd_s) exp_q.push_back('{w, cyc + lat + 1});
        end
        cyc++;
    endtask

    task automatic drain(input int budget, input string tag);
        n = 0;
        while ((src.size() + exp_q.size() > 0) && n < budget) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            n++;
        end
        check_eq(tag, src.size() + exp_q.size(), 0);
    endtask

    initial begin
        sel = 1'b0; lat = 1; depth = 3;
        cyc = 0; errors = 0; checks = 0; delivered = 0;
        post_rst = 1'b0; prev_hold = 1'b0; prev_data = '0;
        rst_a = 1'b0; rst_b = 1'b0; i_rempty = 1'b1; i_ready = 1'b1; i_rdata = '0;

        // Reset with a non-empty FIFO and ready downstream.
        for (int i = 1; i <= 16; i++) src.push_back(DW'(i));
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);

        // Streaming: 16 words, no bubbles -> 2 cycles latency + 16 beats.
        drain(40, "stream_drain");
        check_eq("stream_cycles", n, 18);
        check_eq("stream_words", delivered, 16);

        // Backpressure stall of 5 cycles.
        for (int i = 17; i <= 32; i++) src.push_back(DW'(i));
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("bp_sat_level", level_m, 3);
        check_eq("bp_sat_rd", rd_m, 0);
        drain(60, "bp_drain");
        check_eq("bp_words", delivered, 32);

        // Empty flag rises right after a read is issued.
        for (int i = 33; i <= 40; i++) src.push_back(DW'(i));
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("empty_words", delivered, 34);
        drain(30, "empty_drain");

        // Reset while saturated: buffered and in-flight words are discarded.
        for (int i = 41; i <= 50; i++) src.push_back(DW'(i));
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("mid_rst_level", level_m, 3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("mid_rst_valid", valid_m, 0);
        check_eq("mid_rst_lvl0", level_m, 0);
        drain(40, "mid_rst_drain");
        check_eq("mid_rst_words", delivered, 47);

        // Random run on the RD_LATENCY=3 instance.
        sel = 1'b1; lat = 3; depth = 5;
        src.delete(); exp_q.delete();
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
        delivered = 0; total = 0; n = 0;
        while ((total < 10000 || src.size() + exp_q.size() > 0) && n < 40000) begin
            while (total < 10000 && src.size() < 4) begin
                src.push_back(DW'($urandom));
                total++;
            end
            step(1'b1, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20, 1'b1);
            n++;
        end
        check_eq("rand_drain", src.size() + exp_q.size(), 0);
        check_eq("rand_words", delivered, 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the team's dual-port BRAM FIFO.
- Drives the FIFO read enable from the FIFO's registered almost-empty flag.
- Absorbs the FIFO's registered read-data latency in a small internal skid buffer.
- Presents the words as a valid/ready stream to downstream DSP blocks (e.g. 24-bit audio samples), at full one-word-per-cycle throughput, with no word lost or duplicated under arbitrary backpressure.

Parameters:
- DW, 24: data width, matching the FIFO.
- RD_LATENCY, 1: cycles from o_rd sampled high to the corresponding word on i_rdata (range 1..4).
- BUF_DEPTH, RD_LATENCY+2: skid buffer entries, including the output register (minimum RD_LATENCY+2).
- BW, $clog2(BUF_DEPTH+1): occupancy and credit counter width.

Ports:
- clk  input  1  single clock shared with the FIFO.
- rst  input  1  reset, synchronous, active-low.
- i_rempty  input  1  FIFO (almost-)empty flag, registered by the FIFO; 1 means do not read.
- o_rd  output  1  FIFO read enable; one word per cycle high.
- i_rdata  input  DW  FIFO read data, valid RD_LATENCY cycles after o_rd.
- o_valid  output  1  stream word available.
- o_data  output  DW  stream word.
- i_ready  input  1  downstream accepts o_data when o_valid && i_ready.
- o_level  output  BW  words held in the buffer plus words in flight (status only).

Behaviour:
- Reset (rst==0 at a clk edge):
  - o_valid=0, o_data=0, o_level=0.
  - In-flight shift register cleared; buffer pointers and occupancy set to 0.
  - o_rd is forced 0 while rst==0.
- Reset mid-operation discards in-flight and buffered words. The FIFO itself is not reset by this block; system-level reset must reset both.
- Credit rule (combinational): o_rd = rst && !i_rempty && (occ + inflight) < BUF_DEPTH.
  - occ = words in the buffer, including the o_data register.
  - inflight = number of 1s in an RD_LATENCY-deep shift register fed by o_rd.
- Capture: when the shift register's output bit is 1, i_rdata is written into the buffer in that cycle. Writes are never dropped; the credit rule guarantees space.
- Output:
  - o_valid=1 whenever occ>0.
  - o_data is the oldest buffered word, from the registered head.
  - A handshake (o_valid && i_ready) pops one word.
- Stability: while o_valid && !i_ready, o_data and o_valid hold unchanged.
- Same-cycle capture and pop: occ is unchanged, and order is preserved (FIFO order end to end).
- Capture into an empty buffer: o_valid rises the next cycle.
- Latency: o_rd high in cycle t gives o_valid=1 in cycle t+RD_LATENCY+1 (empty buffer).
- Throughput: with i_rempty=0 and i_ready=1 continuously, o_rd stays 1 every cycle, and after the initial latency o_valid stays 1 every cycle.
- Backpressure:
  - With i_ready=0, o_rd deasserts once occ+inflight reaches BUF_DEPTH.
  - When i_ready returns to 1, o_rd resumes in the same cycle the credit frees.
- Empty boundary: i_rempty rising stops new reads immediately. In-flight words are still captured and delivered.
- Counters: buffer pointers wrap modulo BUF_DEPTH.
- o_level = occ+inflight. It is registered, reflects state after the current edge, and never exceeds BUF_DEPTH.

Test Plan (DW=24, RD_LATENCY=1, BUF_DEPTH=3, FIFO model with 1-cycle read latency, unless noted):
1. Reset: hold rst=0 for 3 cycles with i_rempty=0 and i_ready=1. Required: o_rd=0, o_valid=0, o_data=0, o_level=0 throughout.
2. Streaming:
   - Stimulus: preload the FIFO with 0x000001..0x000010; release reset; i_ready=1.
   - Required: first o_rd in cycle 0; o_valid in cycle 2; 16 words out in order on consecutive cycles; no gaps.
3. Backpressure:
   - Stimulus: streaming as in scenario 2, then i_ready=0 for 5 cycles, then i_ready=1.
   - Required: o_level saturates at 3; o_rd=0 while saturated; o_data held stable; no loss or duplication across the stall.
4. Empty boundary:
   - Stimulus: i_rempty rises in the same cycle o_rd is issued.
   - Required: that in-flight word is still delivered; no further o_rd until i_rempty=0.
5. Mid-operation reset:
   - Stimulus: rst=0 for 1 cycle while o_level=3.
   - Required: o_valid=0 and o_level=0 in the next cycle; old words never appear on o_data.
6. Random:
   - Stimulus: RD_LATENCY=3 (BUF_DEPTH=5); random i_ready and i_rempty; 10k words.
   - Required: scoreboard matches exactly; o_level ≤ 5 always.
